// File: rtl/csat_exhaustive_sequencer_if.sv
// Handshake/result bundle between the exhaustive CSAT sequencer and its environment.
interface csat_exhaustive_sequencer_if #(
  parameter int unsigned N_IN = 13
);
  logic            start_i;
  logic            abort_i;
  logic            sat_i;
  logic [N_IN-1:0] assign_o;
  logic            busy_o;
  logic            done_o;
  logic            found_o;
  logic [N_IN-1:0] solution_o;
  logic [N_IN:0]   checked_o;

  // Environment side: drives control and the benchmark 'sat' result.
  modport master (
    output start_i, abort_i, sat_i,
    input  assign_o, busy_o, done_o, found_o, solution_o, checked_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, abort_i, sat_i,
    output assign_o, busy_o, done_o, found_o, solution_o, checked_o
  );
endinterface

// File: rtl/csat_exhaustive_sequencer.sv
// Brute-force CSAT controller: walks every input assignment, one per clock, and
// stops on the first satisfying one or reports UNSAT after the last.
module csat_exhaustive_sequencer #(
  parameter int unsigned N_IN        = 13,
  parameter int unsigned SAT_LATENCY = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  csat_exhaustive_sequencer_if.slave  bus
);
  localparam int unsigned     CW         = N_IN + 1;
  localparam logic [N_IN-1:0] ASSIGN_MAX = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] assign_q, assign_d;
  logic [N_IN-1:0] solution_q, solution_d;
  logic [CW-1:0]   checked_q, checked_d;
  logic            found_q, found_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            busy_c;
  logic            abort_c;
  logic            issue_c;
  logic            tag_valid_c;
  logic [N_IN-1:0] tag_c;
  logic            hit_c;
  logic            last_c;
  logic            flush_c;

  assign busy_c  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign abort_c = busy_c && bus.abort_i;
  assign issue_c = (state_q == S_RUN);
  assign hit_c   = busy_c && tag_valid_c && bus.sat_i;
  // The final assignment reaching the evaluation point ends a drain.
  assign last_c  = tag_valid_c && (tag_c == ASSIGN_MAX);
  assign flush_c = hit_c || abort_c;

  // Tag pipeline aligning each issued assignment with the sat_i it produces.
  if (SAT_LATENCY == 0) begin : g_no_pipe
    assign tag_valid_c = issue_c;
    assign tag_c       = assign_q;
  end else begin : g_pipe
    logic [SAT_LATENCY-1:0] vld_q, vld_d;
    logic [N_IN-1:0]        tag_q [SAT_LATENCY];
    logic [N_IN-1:0]        tag_d [SAT_LATENCY];

    // Shift in the current issue; a hit or abort discards everything in flight.
    always_comb begin
      vld_d    = '0;
      tag_d    = tag_q;
      vld_d[0] = issue_c && !flush_c;
      tag_d[0] = assign_q;
      for (int i = 1; i < int'(SAT_LATENCY); i++) begin
        vld_d[i] = vld_q[i-1] && !flush_c;
        tag_d[i] = tag_q[i-1];
      end
    end

    // Tag pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < int'(SAT_LATENCY); i++) tag_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        tag_q <= tag_d;
      end
    end

    assign tag_valid_c = vld_q[SAT_LATENCY-1];
    assign tag_c       = tag_q[SAT_LATENCY-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: abort beats hit, hit beats exhaustion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.abort_i)      state_d = S_IDLE;
        else if (bus.start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.abort_i)                state_d = S_IDLE;
        else if (hit_c)                 state_d = S_DONE;
        else if (assign_q == ASSIGN_MAX)
          state_d = (SAT_LATENCY == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.abort_i)           state_d = S_IDLE;
        else if (hit_c || last_c)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; all results are registered.
  always_comb begin
    assign_d   = assign_q;
    solution_d = solution_q;
    checked_d  = checked_q;
    found_d    = found_q;
    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.abort_i) begin
          found_d = 1'b0;
        end else if (bus.start_i) begin
          assign_d   = '0;
          checked_d  = '0;
          found_d    = 1'b0;
          solution_d = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        if (bus.abort_i) begin
          found_d = 1'b0;
        end else begin
          if (tag_valid_c) checked_d = checked_q + CW'(1);
          if (hit_c) begin
            solution_d = tag_c;
            found_d    = 1'b1;
          end else if ((state_q == S_RUN) && (assign_q != ASSIGN_MAX)) begin
            assign_d = assign_q + N_IN'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output/datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assign_q   <= '0;
      solution_q <= '0;
      checked_q  <= '0;
      found_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      assign_q   <= assign_d;
      solution_q <= solution_d;
      checked_q  <= checked_d;
      found_q    <= found_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.assign_o   = assign_q;
  assign bus.solution_o = solution_q;
  assign bus.checked_o  = checked_q;
  assign bus.found_o    = found_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_csat_exhaustive_sequencer.sv
// Bench for csat_exhaustive_sequencer: one instance with SAT_LATENCY=0, one with 2,
// each fed by a benchmark model sat_i = (delayed assign == K).
module tb_csat_exhaustive_sequencer;
  localparam int unsigned N    = 4;
  localparam int          MAXA = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csat_exhaustive_sequencer_if #(.N_IN(N)) bus0 ();
  csat_exhaustive_sequencer_if #(.N_IN(N)) bus2 ();

  csat_exhaustive_sequencer #(.N_IN(N), .SAT_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  csat_exhaustive_sequencer #(.N_IN(N), .SAT_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // Benchmark models.
  logic         force0 = 1'b0, force2 = 1'b0;
  logic         ken0 = 1'b0, ken2 = 1'b0;
  logic [N-1:0] k0 = '0, k2 = '0;
  logic [N-1:0] dl1 = '0, dl2 = '0;

  always @(posedge clk) begin
    dl1 <= bus2.assign_o;
    dl2 <= dl1;
  end
  assign bus0.sat_i = force0 | (ken0 & (bus0.assign_o == k0));
  assign bus2.sat_i = force2 | (ken2 & (dl2 == k2));

  function automatic int rd_assign(int lat);
    return (lat == 0) ? int'(bus0.assign_o) : int'(bus2.assign_o);
  endfunction
  function automatic int rd_solution(int lat);
    return (lat == 0) ? int'(bus0.solution_o) : int'(bus2.solution_o);
  endfunction
  function automatic int rd_checked(int lat);
    return (lat == 0) ? int'(bus0.checked_o) : int'(bus2.checked_o);
  endfunction
  function automatic logic rd_done(int lat);
    return (lat == 0) ? bus0.done_o : bus2.done_o;
  endfunction
  function automatic logic rd_busy(int lat);
    return (lat == 0) ? bus0.busy_o : bus2.busy_o;
  endfunction
  function automatic logic rd_found(int lat);
    return (lat == 0) ? bus0.found_o : bus2.found_o;
  endfunction

  task automatic set_start(input int lat, input logic v);
    if (lat == 0) bus0.start_i = v;
    else          bus2.start_i = v;
  endtask

  // Launch a search and follow it cycle by cycle until done_o or budget.
  task automatic run_search(input int lat, input bit has_k, input int k,
                            output int dc, output bit bok, output bit aok);
    int hitc, ea;
    hitc = has_k ? k + 1 + lat : 1000;
    if (lat == 0) begin ken0 = has_k; k0 = N'(k); end
    else          begin ken2 = has_k; k2 = N'(k); end
    @(negedge clk); set_start(lat, 1'b1);
    @(negedge clk); set_start(lat, 1'b0);
    dc = -1; bok = 1'b1; aok = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      ea = ((c < hitc) ? c : hitc) - 1;
      if (ea > MAXA) ea = MAXA;
      if (rd_assign(lat) != ea) aok = 1'b0;
      if (rd_done(lat)) begin dc = c; break; end
      if (!rd_busy(lat)) bok = 1'b0;
      @(negedge clk);
    end
  endtask

  // Full search compared against the closed-form expectation.
  task automatic test_search(input string name, input int lat, input bit has_k, input int k);
    int dc, exp_done, exp_chk, exp_sol;
    bit bok, aok;
    run_search(lat, has_k, k, dc, bok, aok);
    exp_done = has_k ? k + 2 + lat : (1 << N) + 1 + lat;
    exp_chk  = has_k ? k + 1 : (1 << N);
    exp_sol  = has_k ? k : 0;
    total++; if (dc !== exp_done) begin bad++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, dc, exp_done); end
    total++; if (rd_found(lat) !== has_k) begin bad++;
      $display("FAIL %s found got=%0b exp=%0b", name, rd_found(lat), has_k); end
    total++; if (rd_solution(lat) !== exp_sol) begin bad++;
      $display("FAIL %s solution got=%0d exp=%0d", name, rd_solution(lat), exp_sol); end
    total++; if (rd_checked(lat) !== exp_chk) begin bad++;
      $display("FAIL %s checked got=%0d exp=%0d", name, rd_checked(lat), exp_chk); end
    total++; if (bok !== 1'b1) begin bad++;
      $display("FAIL %s busy_track got=0 exp=1", name); end
    total++; if (aok !== 1'b1) begin bad++;
      $display("FAIL %s assign_track got=0 exp=1 (final assign=%0d)", name, rd_assign(lat)); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if ({bus0.busy_o, bus0.done_o, bus0.found_o} !== 3'b000 ||
                 bus0.assign_o !== '0 || bus0.solution_o !== '0 || bus0.checked_o !== '0) begin
      bad++; $display("FAIL reset dut0 busy/done/found=%b%b%b assign=%0d sol=%0d chk=%0d exp all 0",
        bus0.busy_o, bus0.done_o, bus0.found_o, bus0.assign_o, bus0.solution_o, bus0.checked_o); end
    total++; if ({bus2.busy_o, bus2.done_o, bus2.found_o} !== 3'b000 ||
                 bus2.assign_o !== '0 || bus2.solution_o !== '0 || bus2.checked_o !== '0) begin
      bad++; $display("FAIL reset dut2 busy/done/found=%b%b%b assign=%0d sol=%0d chk=%0d exp all 0",
        bus2.busy_o, bus2.done_o, bus2.found_o, bus2.assign_o, bus2.solution_o, bus2.checked_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // sat_i stuck high while idle must not produce a result; then K=0 search.
  task automatic test_idle_sat_and_k0();
    force0 = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus0.done_o !== 1'b0 || bus0.found_o !== 1'b0 || bus0.busy_o !== 1'b0 ||
                 bus0.checked_o !== '0) begin bad++;
      $display("FAIL idle_sat done=%b found=%b busy=%b chk=%0d exp 0/0/0/0",
        bus0.done_o, bus0.found_o, bus0.busy_o, bus0.checked_o); end
    force0 = 1'b0;
    test_search("k0_lat0", 0, 1'b1, 0);
  endtask

  // Result is frozen in DONE even with sat_i asserted.
  task automatic test_done_hold();
    test_search("hold_lat0", 0, 1'b1, 9);
    force0 = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus0.done_o !== 1'b1 || bus0.found_o !== 1'b1 ||
                 int'(bus0.solution_o) !== 9 || int'(bus0.checked_o) !== 10) begin bad++;
      $display("FAIL done_hold done=%b found=%b sol=%0d chk=%0d exp 1/1/9/10",
        bus0.done_o, bus0.found_o, bus0.solution_o, bus0.checked_o); end
    force0 = 1'b0;
  endtask

  task automatic test_abort();
    ken0 = 1'b0;
    @(negedge clk); bus0.start_i = 1'b1;
    @(negedge clk); bus0.start_i = 1'b0;           // cycle 1
    repeat (3) @(negedge clk);                     // cycle 4
    bus0.abort_i = 1'b1;
    @(negedge clk); bus0.abort_i = 1'b0;           // cycle 5
    total++; if (bus0.busy_o !== 1'b0 || bus0.done_o !== 1'b0 || bus0.found_o !== 1'b0) begin bad++;
      $display("FAIL abort_run busy=%b done=%b found=%b exp 0/0/0",
        bus0.busy_o, bus0.done_o, bus0.found_o); end
    total++; if (int'(bus0.checked_o) != 3 && int'(bus0.checked_o) != 4) begin bad++;
      $display("FAIL abort_partial checked got=%0d exp=3or4", bus0.checked_o); end
    bus0.start_i = 1'b1; bus0.abort_i = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus0.busy_o !== 1'b0 || bus0.done_o !== 1'b0) begin bad++;
      $display("FAIL start_abort_idle busy=%b done=%b exp 0/0", bus0.busy_o, bus0.done_o); end
    bus0.start_i = 1'b0; bus0.abort_i = 1'b0;
    test_search("pre_abort_done", 0, 1'b1, 3);
    bus0.abort_i = 1'b1;
    @(negedge clk); bus0.abort_i = 1'b0;
    total++; if (bus0.done_o !== 1'b0 || bus0.found_o !== 1'b0) begin bad++;
      $display("FAIL abort_done done=%b found=%b exp 0/0", bus0.done_o, bus0.found_o); end
  endtask

  task automatic test_async_reset();
    ken0 = 1'b1; k0 = N'(5);
    @(negedge clk); bus0.start_i = 1'b1;
    @(negedge clk); bus0.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus0.busy_o, bus0.done_o, bus0.found_o} !== 3'b000 ||
                 bus0.assign_o !== '0 || bus0.checked_o !== '0 || bus0.solution_o !== '0) begin bad++;
      $display("FAIL async_reset busy/done/found=%b%b%b assign=%0d chk=%0d exp all 0",
        bus0.busy_o, bus0.done_o, bus0.found_o, bus0.assign_o, bus0.checked_o); end
    @(negedge clk); rst_n = 1'b1;
    test_search("after_reset_k5", 0, 1'b1, 5);
  endtask

  // Restart straight from DONE with a stale delay line that matches the new K.
  task automatic test_back_to_back();
    test_search("b2b_a_lat2", 2, 1'b1, 13);
    test_search("b2b_b_lat2", 2, 1'b1, 15);
    test_search("b2b_c_lat0", 0, 1'b1, 15);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int lat, k;
      bit hk;
      lat = ($urandom_range(1) == 1) ? 2 : 0;
      hk  = ($urandom_range(3) != 0);
      k   = int'($urandom_range(MAXA));
      test_search($sformatf("rand%0d_lat%0d_k%0d_%0b", it, lat, k, hk), lat, hk, k);
    end
  endtask

  initial begin
    bus0.start_i = 1'b0; bus0.abort_i = 1'b0;
    bus2.start_i = 1'b0; bus2.abort_i = 1'b0;
    test_reset();
    test_idle_sat_and_k0();
    test_search("case1_lat0_k5", 0, 1'b1, 5);
    test_search("case2_lat2_unsat", 2, 1'b0, 0);
    test_search("case3_lat2_k15", 2, 1'b1, 15);
    test_search("unsat_lat0", 0, 1'b0, 0);
    test_done_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
